mem_data_dump_reader: RTL and testbench
=======================================

// Module: mem_data_dump_reader
// PURPOSE
//  Read-side initiator for the BIP I data memory (memoria_datos). After a start pulse from the
//  debug unit, reads N consecutive words from a base address and sends each word, MS byte first,
//  as bytes to the UART transmitter. Used to dump data memory to the host after program halt.
// PARAMETERS
//  RAM_WIDTH    16  data word width; must be a multiple of 8 (8..32); BYTES = RAM_WIDTH/8
//  RAM_DEPTH    1024 number of memory entries; addresses wrap modulo RAM_DEPTH
//  ADDR_WIDTH   11  width of address and count ports
//  READ_LATENCY 1   memory read latency in cycles (1 = LOW_LATENCY, 2 = HIGH_PERFORMANCE)
// PORTS
//  i_clk        in  1          clock, rising edge
//  i_reset      in  1          synchronous reset, active high
//  i_start      in  1          one-cycle request to begin a dump
//  i_base_addr  in  ADDR_WIDTH first word address, sampled with i_start
//  i_count      in  ADDR_WIDTH number of words to dump, sampled with i_start
//  o_addr       out ADDR_WIDTH address to memory i_addr
//  o_wea        out 1          write enable to memory; constant 0
//  i_mem_data   in  RAM_WIDTH  memory o_data
//  o_tx_data    out 8          byte to UART transmitter
//  o_tx_start   out 1          one-cycle pulse: o_tx_data valid, start transmission
//  i_tx_done    in  1          one-cycle pulse from transmitter: byte fully sent
//  o_busy       out 1          high from cycle after accepted i_start until o_done
//  o_done       out 1          one-cycle pulse when dump complete
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, byte/word counters cleared. Reset wins over all inputs,
//    including mid-dump: no partial byte, no o_done, any pending i_tx_done ignored.
//  - FSM: IDLE -> READ -> LOAD -> SEND -> WAIT_TX -> (SEND | NEXT) ; NEXT -> READ | FIN ; FIN -> IDLE.
//  - IDLE: i_start=1 latches base/count. count=0 -> FIN directly (o_done pulse, zero bytes).
//    Otherwise o_addr=base, o_busy=1, go READ. i_tx_done in IDLE ignored.
//  - READ: hold o_addr for READ_LATENCY cycles, then LOAD.
//  - LOAD: capture i_mem_data into word register; byte index = BYTES-1.
//  - SEND: o_tx_data = word[8*idx+7 -: 8], o_tx_start=1 for exactly one cycle; go WAIT_TX.
//  - WAIT_TX: o_tx_data held stable; on i_tx_done: idx>0 -> idx-1, SEND; idx=0 -> NEXT.
//    Waits indefinitely; no timeout.
//  - NEXT: words_left-1; if 0 -> FIN; else o_addr = (o_addr+1) mod RAM_DEPTH, READ.
//    Wrap: base=RAM_DEPTH-1, count=2 reads RAM_DEPTH-1 then 0.
//  - FIN: o_done=1 for one cycle, o_busy=0 same cycle, then IDLE (next i_start accepted next cycle).
//  - i_start while o_busy ignored. i_tx_done and i_start simultaneous in IDLE: start accepted.
//  - i_count > RAM_DEPTH is legal; addresses keep wrapping (words re-read).
//  - Latency (READ_LATENCY=1): i_start at cycle 0 -> o_addr valid cycle 1, LOAD cycle 2,
//    first o_tx_start cycle 3. Byte k+1 o_tx_start exactly 1 cycle after i_tx_done of byte k
//    within a word; 3+READ_LATENCY cycles after across words.
//  - o_addr returns to 0 in IDLE/FIN after reset only; otherwise holds last address.
// CONFIGURATION
//  MEM_DUMP_CHECKSUM_EN defined: after the last data byte, FSM sends one extra byte = XOR of all
//   bytes sent in this dump (0x00 for count=0, still sent), same SEND/WAIT_TX handshake, then FIN.
//  Undefined: no checksum byte; FIN follows last data byte's i_tx_done. Checksum logic absent.
// TESTING
//  1 mem[0]=0x000F, mem[1]=0x0102; start base=0,count=2, tx_done 10 cycles after each start
//    -> bytes 0x00,0x0F,0x01,0x02 in order; one o_done; o_wea never 1.
//  2 count=0 -> o_done one cycle after start, zero o_tx_start pulses
//    (checksum build: single byte 0x00).
//  3 base=1023, count=2, mem[1023]=0xABCD, mem[0]=0x1234 -> o_addr 1023 then 0;
//    bytes AB,CD,12,34.
//  4 i_reset asserted while in WAIT_TX of 2nd byte -> next cycle all outputs 0; following
//    i_tx_done produces no o_tx_start; new start resumes cleanly from new base.
//  5 i_start pulses during busy -> ignored; exactly 2*count bytes; base/count unchanged.
//  6 MEM_DUMP_CHECKSUM_EN, data of test 1 -> 5th byte 0x0F^0x01^0x02=0x0C, then o_done;
//    repeat with READ_LATENCY=2 -> same bytes, first o_tx_start at cycle 4.

Source files
------------

// File: rtl/mem_data_dump_reader.sv
// Dumps N consecutive data-memory words to the UART transmitter, MS byte first.
// Define MEM_DUMP_CHECKSUM_EN to append an XOR checksum byte after the last data byte.
module mem_data_dump_reader #(
   parameter int RAM_WIDTH    = 16,
   parameter int RAM_DEPTH    = 1024,
   parameter int ADDR_WIDTH   = 11,
   parameter int READ_LATENCY = 1
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_base_addr,
   input  logic [ADDR_WIDTH-1:0] i_count,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic                  o_wea,
   input  logic [RAM_WIDTH-1:0]  i_mem_data,
   output logic [7:0]            o_tx_data,
   output logic                  o_tx_start,
   input  logic                  i_tx_done,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int BYTES = RAM_WIDTH / 8;
   localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [READ_LATENCY-1:0] PIPE_SEED = READ_LATENCY'(1);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      LOAD,
      SEND,
      WAIT_TX,
      NEXT,
      FIN
   } state_t;

   state_t                      state, state_nxt;
   logic [ADDR_WIDTH-1:0]       addr_q;
   logic [ADDR_WIDTH-1:0]       words_left;
   logic [BYTES-1:0][7:0]       word_q;
   logic [IDX_W-1:0]            idx;
   logic [READ_LATENCY-1:0]     vld_pipe;
   logic [ADDR_WIDTH-1:0]       addr_inc;
   logic                        last_word;
   logic                        count_zero;

`ifdef MEM_DUMP_CHECKSUM_EN
   logic [7:0]                  csum_q;
   logic                        csum_phase;
`endif

   assign o_wea      = 1'b0;
   assign o_addr     = addr_q;
   assign count_zero = (i_count == '0);
   assign last_word  = (words_left == ADDR_WIDTH'(1));
   assign addr_inc   = (addr_q >= ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : addr_q + 1'b1;

`ifdef MEM_DUMP_CHECKSUM_EN
   assign o_tx_data = csum_phase ? csum_q : word_q[idx];
`else
   assign o_tx_data = word_q[idx];
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      o_busy     = 1'b0;
      o_done     = 1'b0;
      o_tx_start = 1'b0;
      case (state)
         IDLE: begin
            if (i_start) begin
               if (count_zero) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                  state_nxt = SEND;
`else
                  state_nxt = FIN;
`endif
               end else begin
                  state_nxt = READ;
               end
            end
         end
         READ: begin
            o_busy = 1'b1;
            if (vld_pipe[READ_LATENCY-1]) state_nxt = LOAD;
         end
         LOAD: begin
            o_busy    = 1'b1;
            state_nxt = SEND;
         end
         SEND: begin
            o_busy     = 1'b1;
            o_tx_start = 1'b1;
            state_nxt  = WAIT_TX;
         end
         WAIT_TX: begin
            o_busy = 1'b1;
            if (i_tx_done) begin
`ifdef MEM_DUMP_CHECKSUM_EN
               if (csum_phase)       state_nxt = FIN;
               else if (idx != '0)   state_nxt = SEND;
               else                  state_nxt = NEXT;
`else
               if (idx != '0) state_nxt = SEND;
               else           state_nxt = NEXT;
`endif
            end
         end
         NEXT: begin
            o_busy = 1'b1;
            if (last_word) begin
`ifdef MEM_DUMP_CHECKSUM_EN
               state_nxt = SEND;
`else
               state_nxt = FIN;
`endif
            end else begin
               state_nxt = READ;
            end
         end
         FIN: begin
            o_done    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: address/word counters, captured word, byte index, read-latency pipe.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         addr_q     <= '0;
         words_left <= '0;
         word_q     <= '0;
         idx        <= '0;
         vld_pipe   <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
         csum_q     <= '0;
         csum_phase <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (i_start) begin
                  words_left <= i_count;
                  vld_pipe   <= PIPE_SEED;
                  if (!count_zero) addr_q <= i_base_addr;
`ifdef MEM_DUMP_CHECKSUM_EN
                  csum_q     <= '0;
                  csum_phase <= count_zero;
`endif
               end
            end
            READ: vld_pipe <= vld_pipe << 1;
            LOAD: begin
               word_q <= i_mem_data;
               idx    <= IDX_W'(BYTES - 1);
            end
`ifdef MEM_DUMP_CHECKSUM_EN
            SEND: begin
               if (!csum_phase) csum_q <= csum_q ^ word_q[idx];
            end
`endif
            WAIT_TX: begin
               if (i_tx_done && idx != '0) idx <= idx - 1'b1;
            end
            NEXT: begin
               words_left <= words_left - 1'b1;
               if (!last_word) begin
                  addr_q   <= addr_inc;
                  vld_pipe <= PIPE_SEED;
               end
`ifdef MEM_DUMP_CHECKSUM_EN
               else begin
                  csum_phase <= 1'b1;
               end
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_data_dump_reader.sv
// Scoreboard bench for mem_data_dump_reader: a reference model queues expected bytes/done
// events with their cycle spacing; a monitor pops and compares as the DUT emits them.
module tb_mem_data_dump_reader;

   localparam int AW    = 11;
   localparam int RW    = 16;
   localparam int DEPTH = 1024;
   localparam int RL    = 1;
   localparam int BYTES = RW / 8;

   logic          i_clk = 1'b0;
   logic          i_reset;
   logic          i_start;
   logic [AW-1:0] i_base_addr;
   logic [AW-1:0] i_count;
   logic [AW-1:0] o_addr;
   logic          o_wea;
   logic [RW-1:0] i_mem_data;
   logic [7:0]    o_tx_data;
   logic          o_tx_start;
   logic          i_tx_done;
   logic          o_busy;
   logic          o_done;

   always #5 i_clk = ~i_clk;

   mem_data_dump_reader #(
      .RAM_WIDTH(RW), .RAM_DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(RL)
   ) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_base_addr(i_base_addr),
      .i_count(i_count), .o_addr(o_addr), .o_wea(o_wea), .i_mem_data(i_mem_data),
      .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
      .o_busy(o_busy), .o_done(o_done)
   );

   logic [RW-1:0] mem [DEPTH];
   always @(posedge i_clk) i_mem_data <= mem[int'(o_addr) % DEPTH];

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] b;
      int         gap;
      bit         is_done;
   } exp_t;

   exp_t       exp_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         ref_cyc  = 0;
   int         tx_cnt   = 0;
   int         tx_fixed = 10;
   logic [7:0] last_byte = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Reference: words base..base+count-1 modulo depth, each MS byte first.
   // First byte arrives 2+RL cycles after start; next byte in a word 1 cycle after the
   // previous tx_done, first byte of a later word 3+RL cycles after it.
   task automatic push_dump(input int base, input int count);
      logic [7:0] x;
      exp_t       e;
      x = 8'h00;
      for (int w = 0; w < count; w++) begin
         int a;
         a = (base + w) % DEPTH;
         for (int k = BYTES - 1; k >= 0; k--) begin
            e.b       = mem[a][8*k +: 8];
            e.is_done = 1'b0;
            e.gap     = (k != BYTES - 1) ? 1 : ((w == 0) ? 2 + RL : 3 + RL);
            x         = x ^ e.b;
            exp_q.push_back(e);
         end
      end
`ifdef MEM_DUMP_CHECKSUM_EN
      e.b = x; e.is_done = 1'b0; e.gap = (count == 0) ? 1 : 2;
      exp_q.push_back(e);
      e.b = 8'h00; e.is_done = 1'b1; e.gap = 1;
      exp_q.push_back(e);
`else
      e.b = 8'h00; e.is_done = 1'b1; e.gap = (count == 0) ? 1 : 2;
      exp_q.push_back(e);
`endif
   endtask

   task automatic start_dump(input int base, input int count);
      bit exp_busy;
      tick();
      i_start     = 1'b1;
      i_base_addr = AW'(base);
      i_count     = AW'(count);
      push_dump(base, count);
      ref_cyc     = cyc;
      tick();
      i_start     = 1'b0;
      i_base_addr = AW'($urandom);
      i_count     = AW'($urandom);
`ifdef MEM_DUMP_CHECKSUM_EN
      exp_busy = 1'b1;
`else
      exp_busy = (count != 0);
`endif
      chk("busy_after_start", {31'd0, o_busy}, {31'd0, exp_busy});
      if (count != 0) chk("addr_after_start", {21'd0, o_addr}, base);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      chk("dump_complete_pending", exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Transmitter model: tx_done pulse a fixed or random number of cycles after tx_start.
   initial begin
      int d;
      i_tx_done = 1'b0;
      forever begin
         @(negedge i_clk);
         if (o_tx_start === 1'b1) begin
            d = (tx_fixed > 0) ? tx_fixed : int'($urandom_range(1, 12));
            repeat (d) @(posedge i_clk);
            #1 i_tx_done = 1'b1;
            @(posedge i_clk);
            #1 i_tx_done = 1'b0;
         end
      end
   end

   // Monitor: pops the scoreboard on every tx_start / done the DUT presents.
   initial begin
      exp_t e;
      forever begin
         @(negedge i_clk);
         if (i_reset !== 1'b1) begin
            if (o_tx_start === 1'b1) begin
               tx_cnt++;
               if (exp_q.size() == 0 || exp_q[0].is_done) begin
                  chk("unexpected_tx_start", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("tx_byte", {24'd0, o_tx_data}, {24'd0, e.b});
                  chk("tx_gap", cyc - ref_cyc, e.gap);
                  chk("busy_during_tx", {31'd0, o_busy}, 1);
                  chk("wea_zero", {31'd0, o_wea}, 0);
                  last_byte = o_tx_data;
               end
            end
            if (o_done === 1'b1) begin
               if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                  chk("unexpected_done", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("done_gap", cyc - ref_cyc, e.gap);
                  chk("busy_low_at_done", {31'd0, o_busy}, 0);
               end
            end
            if (i_tx_done === 1'b1 && o_busy === 1'b1) begin
               chk("tx_data_held", {24'd0, o_tx_data}, {24'd0, last_byte});
               ref_cyc = cyc;
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: time limit reached with %0d checks", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int base_cnt;
      int n;
      i_reset     = 1'b1;
      i_start     = 1'b0;
      i_base_addr = '0;
      i_count     = '0;
      for (int i = 0; i < DEPTH; i++) mem[i] = RW'($urandom);
      repeat (3) tick();
      chk("reset_outputs", {9'd0, o_addr, o_wea, o_tx_data, o_tx_start, o_busy, o_done}, 0);
      i_reset = 1'b0;

      // basic two-word dump
      mem[0] = 16'h000F;
      mem[1] = 16'h0102;
      tx_fixed = 10;
      start_dump(0, 2);
      wait_idle(200);

      // zero-length dump
      start_dump(0, 0);
      wait_idle(50);

      // address wrap at top of memory
      mem[1023] = 16'hABCD;
      mem[0]    = 16'h1234;
      start_dump(1023, 2);
      wait_idle(200);

      // reset while waiting on the second byte
      base_cnt = tx_cnt;
      start_dump(256, 3);
      n = 0;
      while (tx_cnt < base_cnt + 2 && n < 200) begin
         tick();
         n++;
      end
      chk("reached_second_byte", tx_cnt - base_cnt, 2);
      repeat (3) tick();
      i_reset = 1'b1;
      exp_q.delete();
      tick();
      i_reset = 1'b0;
      chk("reset_mid_dump", {9'd0, o_addr, o_wea, o_tx_data, o_tx_start, o_busy, o_done}, 0);
      repeat (15) tick();
      chk("no_tx_after_reset", tx_cnt - base_cnt, 2);
      start_dump(512, 2);
      wait_idle(200);

      // start pulses while busy are ignored
      start_dump(100, 3);
      for (int j = 0; j < 6; j++) begin
         tick();
         if (o_busy === 1'b1) begin
            i_start     = 1'b1;
            i_base_addr = AW'($urandom);
            i_count     = AW'($urandom_range(1, 20));
            tick();
            i_start = 1'b0;
         end
      end
      wait_idle(400);

      // randomized dumps with random transmitter delay
      tx_fixed = 0;
      for (int r = 0; r < 10; r++) begin
         start_dump(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 6)));
         wait_idle(2000);
      end

      // count beyond memory depth keeps wrapping
      tx_fixed = 1;
      start_dump(1020, 1030);
      wait_idle(20000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
